// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file parameters and the write-back request record used by
// the write-back scheduler.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: on a contest the requester that did not win
// last time is granted. Grants are combinational and forced low during reset.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 won last, so requester 0 wins the first contest.
    logic last_grant;

    always_comb begin
        gnt0 = !rst && req0 && (!req1 || last_grant);
        gnt1 = !rst && req1 && (!req0 || !last_grant);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_grant <= gnt1;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin merge of two write-back requesters onto the
// register-file write port plus a per-register pending-write scoreboard.
// Optional feature macro REGFILE_WB_BYPASS_EN clears busy in the cycle of the
// last outstanding write.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_ena,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  issue_ready,
    input  logic                  wb0_valid,
    input  logic [REG_ADDR_W-1:0] wb0_addr,
    input  logic [XLEN-1:0]       wb0_data,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [REG_ADDR_W-1:0] wb1_addr,
    input  logic [XLEN-1:0]       wb1_data,
    output logic                  wb1_ready,
    output logic                  wr_ena,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr0,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic                  busy0,
    output logic                  busy1,
    output logic                  sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wb_req_t req0, req1, sel;
    logic    gnt0, gnt1, issue_fire;
    logic [NUM_REGS-1:0]            inc_vec, dec_vec;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0.valid),
        .req1 (req1.valid),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Entry 0 of cnt is held at zero, so x0 never reads busy or blocks issue.
    function automatic logic is_busy(input logic [REG_ADDR_W-1:0] addr);
        logic b;
        b = !rst && (cnt[addr] != '0);
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_ena && wr_addr == addr && cnt[addr] == CNT_ONE) b = 1'b0;
`endif
        return b;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and infers a latch.
    always_comb begin
        req0        = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
        req1        = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};
        sel         = gnt1 ? req1 : req0;
        wb0_ready   = gnt0;
        wb1_ready   = gnt1;
        wr_ena      = (gnt0 || gnt1) && sel.valid && (sel.addr != '0);
        wr_addr     = sel.addr;
        wr_data     = sel.data;
        issue_ready = !rst && (issue_addr == '0 || cnt[issue_addr] != CNT_MAX);
        issue_fire  = issue_ena && issue_ready && (issue_addr != '0);
        busy0       = is_busy(rd_addr0);
        busy1       = is_busy(rd_addr1);

        inc_vec = '0;
        dec_vec = '0;
        if (issue_fire) inc_vec[issue_addr] = 1'b1;
        if (wr_ena && cnt[wr_addr] != '0) dec_vec[wr_addr] = 1'b1;
    end

    // NOTE: the counters are plain flops read combinationally every cycle, not
    // a RAM, so they are reset like any other control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sb_err <= 1'b0;
        end else begin
            cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) cnt[i] <= cnt[i] + 1'b1;
                else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - 1'b1;
            end
            // A write-back with no matching issue means the pipeline lost track.
            if (wr_ena && cnt[wr_addr] == '0) sb_err <= 1'b1;
        end
    end

endmodule
